// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line, frame configuration and received-byte outputs of the UART receiver.
interface uart_rx_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
);
    logic                   rx_in;
    logic [PRESC_WIDTH-1:0] prescale;
    logic                   par_en;
    logic                   par_typ;
    logic [DATA_WIDTH-1:0]  p_data;
    logic                   data_valid;
    logic                   par_err;
    logic                   stp_err;

    modport master (
        output rx_in, prescale, par_en, par_typ,
        input  p_data, data_valid, par_err, stp_err
    );

    modport slave (
        input  rx_in, prescale, par_en, par_typ,
        output p_data, data_valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority vote, optional parity and stop check.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input logic     clk,
    input logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH + 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [PRESC_WIDTH-1:0] edge_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [PRESC_WIDTH-1:0] p_lat;
    logic                   par_en_l;
    logic                   par_typ_l;
    logic [2:0]             samp;
    logic [DATA_WIDTH-1:0]  shift;
    logic                   par_bad;
    logic [PRESC_WIDTH-1:0] p_in;
    logic [PRESC_WIDTH-1:0] half;
    logic                   last;
    logic                   decide;
    logic                   maj;
    logic                   exp_par;
    logic                   good;

    // Unsupported ratios fall back to 8x oversampling.
    assign p_in    = (bus.prescale == PRESC_WIDTH'(16) || bus.prescale == PRESC_WIDTH'(32)) ?
                     bus.prescale : PRESC_WIDTH'(8);
    assign half    = p_lat >> 1;
    assign last    = edge_cnt == p_lat - PRESC_WIDTH'(1);
    assign decide  = edge_cnt == half + PRESC_WIDTH'(2);
    assign maj     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign exp_par = ^shift ^ par_typ_l;
    assign good    = maj && !par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            p_lat          <= PRESC_WIDTH'(8);
            par_en_l       <= 1'b0;
            par_typ_l      <= 1'b0;
            samp           <= '0;
            shift          <= '0;
            par_bad        <= 1'b0;
            bus.p_data     <= '0;
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
        end else begin
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stp_err    <= 1'b0;
            if (state != IDLE) begin
                edge_cnt <= last ? '0 : edge_cnt + PRESC_WIDTH'(1);
                bit_cnt  <= last ? bit_cnt + BW'(1) : bit_cnt;
                if (edge_cnt == half - PRESC_WIDTH'(1)) samp[0] <= bus.rx_in;
                if (edge_cnt == half) samp[1] <= bus.rx_in;
                if (edge_cnt == half + PRESC_WIDTH'(1)) samp[2] <= bus.rx_in;
            end
            case (state)
                IDLE: if (!bus.rx_in) begin
                    state     <= START;
                    edge_cnt  <= PRESC_WIDTH'(1);
                    bit_cnt   <= '0;
                    p_lat     <= p_in;
                    par_en_l  <= bus.par_en;
                    par_typ_l <= bus.par_typ;
                    par_bad   <= 1'b0;
                end
                START: if (decide && maj) state <= IDLE;
                       else if (last) state <= DATA;
                DATA: begin
                    if (decide) shift <= {maj, shift[DATA_WIDTH-1:1]};
                    if (last && bit_cnt == BW'(DATA_WIDTH)) state <= par_en_l ? PARITY : STOP;
                end
                PARITY: begin
                    if (decide) par_bad <= maj != exp_par;
                    if (last) state <= STOP;
                end
                STOP: if (decide) begin
                    // Leave before the wrap so a back-to-back start bit is caught.
                    state          <= IDLE;
                    bus.data_valid <= good;
                    bus.par_err    <= par_bad;
                    bus.stp_err    <= !maj;
                    bus.p_data     <= good ? shift : bus.p_data;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame scenarios for uart_rx with hand-computed pulse indices and data.
module tb_uart_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   dv_n = 0, pe_n = 0, se_n = 0;
    int   dv_at = 0, dv_prev = 0, pe_at = 0, se_at = 0;
    int   stretch = 0;
    logic dv_q = 1'b0, pe_q = 1'b0, se_q = 1'b0;

    uart_rx_if bus ();
    uart_rx dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log sampled mid-cycle; the cycle index is the number of rising edges seen so far.
    always @(negedge clk) begin
        if (bus.data_valid) begin dv_n++; dv_prev = dv_at; dv_at = cyc; end
        if (bus.par_err) begin pe_n++; pe_at = cyc; end
        if (bus.stp_err) begin se_n++; se_at = cyc; end
        if ((bus.data_valid && dv_q) || (bus.par_err && pe_q) || (bus.stp_err && se_q)) stretch++;
        dv_q = bus.data_valid;
        pe_q = bus.par_err;
        se_q = bus.stp_err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int p, input logic pe, input logic pt);
        bus.prescale = 6'(p);
        bus.par_en   = pe;
        bus.par_typ  = pt;
    endtask

    // Drives one frame starting at index 0 = first cycle of the start bit; gk flips one mid-bit sample.
    task automatic send(input logic [7:0] d, input int p, input logic has_par, input logic pb,
                        input logic stp, input int gk, output int t0);
        logic [10:0] fr;
        int n;
        n  = has_par ? 11 : 10;
        fr = has_par ? {stp, pb, d, 1'b0} : {1'b0, stp, d, 1'b0};
        t0 = cyc;
        for (int k = 0; k < n; k++)
            for (int e = 0; e < p; e++) begin
                bus.rx_in = (k == gk && e == p / 2) ? ~fr[k] : fr[k];
                tick();
            end
        bus.rx_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        tests++;
        if ({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", {bus.p_data, bus.data_valid, bus.par_err, bus.stp_err});
        end
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_even_parity();
        int t0, d0, e0;
        d0 = dv_n; e0 = pe_n + se_n;
        cfg(8, 1, 0);
        send(8'h55, 8, 1, 0, 1, -1, t0);
        repeat (4) tick();
        tests++; if (dv_n - d0 !== 1) begin fails++; $display("FAIL even_dv_count: got %0d want 1", dv_n - d0); end
        tests++; if (dv_at - t0 !== 87) begin fails++; $display("FAIL even_dv_index: got %0d want 87", dv_at - t0); end
        tests++; if (bus.p_data !== 8'h55) begin fails++; $display("FAIL even_data: got %h want 55", bus.p_data); end
        tests++; if (pe_n + se_n - e0 !== 0) begin fails++; $display("FAIL even_errors: got %0d want 0", pe_n + se_n - e0); end
    endtask

    task automatic test_no_parity();
        int t0, d0, e0;
        d0 = dv_n; e0 = pe_n + se_n;
        cfg(16, 0, 1);
        send(8'hA7, 16, 0, 0, 1, -1, t0);
        repeat (4) tick();
        tests++; if (dv_n - d0 !== 1) begin fails++; $display("FAIL nopar_dv_count: got %0d want 1", dv_n - d0); end
        tests++; if (dv_at - t0 !== 155) begin fails++; $display("FAIL nopar_dv_index: got %0d want 155", dv_at - t0); end
        tests++; if (bus.p_data !== 8'hA7) begin fails++; $display("FAIL nopar_data: got %h want a7", bus.p_data); end
        tests++; if (pe_n + se_n - e0 !== 0) begin fails++; $display("FAIL nopar_errors: got %0d want 0", pe_n + se_n - e0); end
    endtask

    task automatic test_parity_error();
        int t0, d0, p0;
        d0 = dv_n; p0 = pe_n;
        cfg(8, 1, 1);
        // 0x57 has five ones, so odd parity needs 0; 1 is the wrong bit.
        send(8'h57, 8, 1, 1, 1, -1, t0);
        repeat (4) tick();
        tests++; if (pe_n - p0 !== 1) begin fails++; $display("FAIL parerr_count: got %0d want 1", pe_n - p0); end
        tests++; if (pe_at - t0 !== 87) begin fails++; $display("FAIL parerr_index: got %0d want 87", pe_at - t0); end
        tests++; if (dv_n - d0 !== 0) begin fails++; $display("FAIL parerr_dv: got %0d want 0", dv_n - d0); end
        tests++; if (bus.p_data !== 8'hA7) begin fails++; $display("FAIL parerr_hold: got %h want a7", bus.p_data); end
    endtask

    task automatic test_stop_error();
        int t0, d0, s0, p0;
        d0 = dv_n; s0 = se_n; p0 = pe_n;
        cfg(32, 0, 0);
        send(8'h3C, 32, 0, 0, 0, -1, t0);
        repeat (60) tick();
        tests++; if (se_n - s0 !== 1) begin fails++; $display("FAIL stperr_count: got %0d want 1", se_n - s0); end
        tests++; if (se_at - t0 !== 307) begin fails++; $display("FAIL stperr_index: got %0d want 307", se_at - t0); end
        tests++; if (dv_n - d0 + pe_n - p0 !== 0) begin fails++; $display("FAIL stperr_other: got %0d want 0", dv_n - d0 + pe_n - p0); end
        tests++; if (bus.p_data !== 8'hA7) begin fails++; $display("FAIL stperr_hold: got %h want a7", bus.p_data); end
    endtask

    task automatic test_false_start();
        int t0, f0;
        f0 = dv_n + pe_n + se_n;
        cfg(8, 0, 0);
        bus.rx_in = 1'b0;
        repeat (3) tick();
        bus.rx_in = 1'b1;
        repeat (12) tick();
        tests++; if (dv_n + pe_n + se_n - f0 !== 0) begin fails++; $display("FAIL false_start_flags: got %0d want 0", dv_n + pe_n + se_n - f0); end
        send(8'h81, 8, 0, 0, 1, -1, t0);
        repeat (4) tick();
        tests++; if (dv_at - t0 !== 79) begin fails++; $display("FAIL false_start_next_index: got %0d want 79", dv_at - t0); end
        tests++; if (bus.p_data !== 8'h81) begin fails++; $display("FAIL false_start_next_data: got %h want 81", bus.p_data); end
    endtask

    task automatic test_bad_prescale();
        int t0;
        cfg(12, 0, 0);
        send(8'hC3, 8, 0, 0, 1, -1, t0);
        repeat (4) tick();
        tests++; if (dv_at - t0 !== 79) begin fails++; $display("FAIL badpresc_index: got %0d want 79", dv_at - t0); end
        tests++; if (bus.p_data !== 8'hC3) begin fails++; $display("FAIL badpresc_data: got %h want c3", bus.p_data); end
    endtask

    task automatic test_back_to_back();
        int t0, t1, d0;
        d0 = dv_n;
        cfg(16, 1, 0);
        send(8'h12, 16, 1, 0, 1, -1, t0);
        send(8'h34, 16, 1, 1, 1, -1, t1);
        repeat (4) tick();
        tests++; if (dv_n - d0 !== 2) begin fails++; $display("FAIL b2b_count: got %0d want 2", dv_n - d0); end
        tests++; if (dv_at - dv_prev !== 176) begin fails++; $display("FAIL b2b_spacing: got %0d want 176", dv_at - dv_prev); end
        tests++; if (dv_at - t1 !== 171) begin fails++; $display("FAIL b2b_index: got %0d want 171", dv_at - t1); end
        tests++; if (bus.p_data !== 8'h34) begin fails++; $display("FAIL b2b_data: got %h want 34", bus.p_data); end
    endtask

    task automatic test_reset_mid_frame();
        int t0, f0;
        f0 = dv_n + pe_n + se_n;
        cfg(8, 0, 0);
        bus.rx_in = 1'b0;
        repeat (8) tick();
        bus.rx_in = 1'b1;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.p_data, bus.data_valid, bus.par_err, bus.stp_err} !== 11'd0) begin
            fails++;
            $display("FAIL midrst_outputs: got %h want 0", {bus.p_data, bus.data_valid, bus.par_err, bus.stp_err});
        end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (100) tick();
        tests++; if (dv_n + pe_n + se_n - f0 !== 0) begin fails++; $display("FAIL midrst_no_pulse: got %0d want 0", dv_n + pe_n + se_n - f0); end
        send(8'h5A, 8, 0, 0, 1, -1, t0);
        repeat (4) tick();
        tests++; if (dv_at - t0 !== 79) begin fails++; $display("FAIL midrst_next_index: got %0d want 79", dv_at - t0); end
        tests++; if (bus.p_data !== 8'h5A) begin fails++; $display("FAIL midrst_next_data: got %h want 5a", bus.p_data); end
    endtask

    task automatic test_glitch();
        int t0, e0;
        e0 = pe_n + se_n;
        cfg(16, 0, 0);
        send(8'h96, 16, 0, 0, 1, 3, t0);
        repeat (4) tick();
        tests++; if (bus.p_data !== 8'h96) begin fails++; $display("FAIL glitch_data_bit: got %h want 96", bus.p_data); end
        send(8'h0F, 16, 0, 0, 1, 0, t0);
        repeat (4) tick();
        tests++; if (dv_at - t0 !== 155) begin fails++; $display("FAIL glitch_start_index: got %0d want 155", dv_at - t0); end
        tests++; if (bus.p_data !== 8'h0F) begin fails++; $display("FAIL glitch_start_data: got %h want 0f", bus.p_data); end
        tests++; if (pe_n + se_n - e0 !== 0) begin fails++; $display("FAIL glitch_errors: got %0d want 0", pe_n + se_n - e0); end
    endtask

    task automatic test_config_latch();
        int t0, e0;
        e0 = pe_n + se_n;
        cfg(16, 0, 0);
        fork
            send(8'hE1, 16, 0, 0, 1, -1, t0);
            begin repeat (5) tick(); cfg(8, 1, 1); end
        join
        repeat (4) tick();
        tests++; if (dv_at - t0 !== 155) begin fails++; $display("FAIL latch_index: got %0d want 155", dv_at - t0); end
        tests++; if (bus.p_data !== 8'hE1) begin fails++; $display("FAIL latch_data: got %h want e1", bus.p_data); end
        tests++; if (pe_n + se_n - e0 !== 0) begin fails++; $display("FAIL latch_errors: got %0d want 0", pe_n + se_n - e0); end
        tests++; if (stretch !== 0) begin fails++; $display("FAIL pulse_width: got %0d stretched want 0", stretch); end
    endtask

    initial begin
        bus.rx_in = 1'b1;
        cfg(8, 0, 0);
        test_reset();
        test_even_parity();
        test_no_parity();
        test_parity_error();
        test_stop_error();
        test_false_start();
        test_bad_prescale();
        test_back_to_back();
        test_reset_mid_frame();
        test_glitch();
        test_config_latch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
